// File: rtl/rtc_pkg.sv
// Shared RTC definitions: register addresses, sequencer state encoding, BCD limits.
// Used by both the write and read sequencers.
package rtc_pkg;

  localparam logic [7:0] RTC_ADDR_SEG = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN = 8'h22;
  localparam logic [7:0] RTC_ADDR_HOR = 8'h23;

  localparam logic [7:0] BCD_MAX_SEG = 8'h59;
  localparam logic [7:0] BCD_MAX_MIN = 8'h59;
  localparam logic [7:0] BCD_MAX_HOR = 8'h23;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ADDR_ASSERT,
    ADDR_RELEASE,
    DATA_ASSERT,
    DATA_RELEASE,
    FINISH
  } rtc_state_t;

  typedef struct packed {
    logic [7:0] hor;
    logic [7:0] min;
    logic [7:0] seg;
  } rtc_time_t;

  // Both nibbles must be decimal digits; the packed compare then matches decimal order.
  function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter for RTC bus phase timing; tc is high while the count sits at zero.
// A load takes effect on the next edge, so a phase loaded with N-1 lasts N cycles.
module rtc_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/rtc_write_seq.sv
// Writes a snapshot of the BCD time into the RTC over its multiplexed A/D bus:
// seconds, minutes, hours, each as an address phase then a data phase; all outputs registered.
module rtc_write_seq
  import rtc_pkg::*;
#(
  parameter int         T_PHASE  = 10,
  parameter logic [7:0] ADDR_SEG = RTC_ADDR_SEG,
  parameter logic [7:0] ADDR_MIN = RTC_ADDR_MIN,
  parameter logic [7:0] ADDR_HOR = RTC_ADDR_HOR
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] SEG_in,
  input  logic [7:0] MIN_in,
  input  logic [7:0] HOR_in,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       A_D,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [CW-1:0] PH_LAST = CW'(T_PHASE - 1);

  rtc_state_t state;
  rtc_time_t  snap;
  logic [1:0] idx;
  logic       snap_ok;
  logic       in_phase;
  logic       ph_load;
  logic       ph_tc;

  function automatic logic [7:0] reg_addr(input logic [1:0] i);
    case (i)
      2'd0:    return ADDR_SEG;
      2'd1:    return ADDR_MIN;
      default: return ADDR_HOR;
    endcase
  endfunction

  function automatic logic [7:0] reg_data(input rtc_time_t t, input logic [1:0] i);
    case (i)
      2'd0:    return t.seg;
      2'd1:    return t.min;
      default: return t.hor;
    endcase
  endfunction

  assign snap_ok = bcd_in_range(snap.seg, BCD_MAX_SEG) &&
                   bcd_in_range(snap.min, BCD_MAX_MIN) &&
                   bcd_in_range(snap.hor, BCD_MAX_HOR);

  assign in_phase = state inside {ADDR_ASSERT, ADDR_RELEASE, DATA_ASSERT, DATA_RELEASE};

  // Reload on entry to the first phase and on every phase boundary.
  assign ph_load = (state == CHECK) || (in_phase && ph_tc);

  rtc_phase_timer #(
    .WIDTH(CW)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (ph_load),
    .load_val (PH_LAST),
    .tc       (ph_tc)
  );

  // This block never reads the RTC.
  assign RD_n = 1'b1;

  // AD_out/A_D are only updated on the same edge that moves CS_n, so they are
  // stable for the whole WR_n-low window.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      snap   <= '0;
      idx    <= 2'd0;
      AD_out <= 8'h00;
      AD_oe  <= 1'b0;
      A_D    <= 1'b0;
      CS_n   <= 1'b1;
      WR_n   <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            snap  <= '{hor: HOR_in, min: MIN_in, seg: SEG_in};
            state <= CHECK;
          end
        end

        CHECK: begin
          if (!snap_ok) begin
            ERR   <= 1'b1;
            state <= IDLE;
          end else begin
            BUSY   <= 1'b1;
            idx    <= 2'd0;
            AD_oe  <= 1'b1;
            AD_out <= reg_addr(2'd0);
            A_D    <= 1'b0;
            CS_n   <= 1'b0;
            WR_n   <= 1'b0;
            state  <= ADDR_ASSERT;
          end
        end

        ADDR_ASSERT: begin
          if (ph_tc) begin
            CS_n  <= 1'b1;
            WR_n  <= 1'b1;
            state <= ADDR_RELEASE;
          end
        end

        ADDR_RELEASE: begin
          if (ph_tc) begin
            AD_out <= reg_data(snap, idx);
            A_D    <= 1'b1;
            CS_n   <= 1'b0;
            WR_n   <= 1'b0;
            state  <= DATA_ASSERT;
          end
        end

        DATA_ASSERT: begin
          if (ph_tc) begin
            CS_n  <= 1'b1;
            WR_n  <= 1'b1;
            state <= DATA_RELEASE;
          end
        end

        DATA_RELEASE: begin
          if (ph_tc) begin
            if (idx == 2'd2) begin
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              AD_oe <= 1'b0;
              state <= FINISH;
            end else begin
              idx    <= idx + 2'd1;
              AD_out <= reg_addr(idx + 2'd1);
              A_D    <= 1'b0;
              CS_n   <= 1'b0;
              WR_n   <= 1'b0;
              state  <= ADDR_ASSERT;
            end
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_write_seq.sv
// Bench for rtc_write_seq: directed and random write requests, a bus-rule monitor,
// and a transaction-level expectation built from the time values and address map.
module tb_rtc_write_seq;

  localparam int TP = 10;
  localparam int LAT = 2 + 12 * TP;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [7:0] SEG_in, MIN_in, HOR_in;
  logic [7:0] AD_out;
  logic       AD_oe, A_D, CS_n, WR_n, RD_n, BUSY, DONE, ERR;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [8:0] wr_log[$];
  int         done_log[$];
  int         err_log[$];
  int         pulse_log[$];
  int         busy_cnt;
  int         wr_run;
  logic       prev_cs, prev_wr;
  logic [8:0] prev_ad;

  rtc_write_seq #(
    .T_PHASE  (TP),
    .ADDR_SEG (8'h21),
    .ADDR_MIN (8'h22),
    .ADDR_HOR (8'h23)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .SEG_in (SEG_in),
    .MIN_in (MIN_in),
    .HOR_in (HOR_in),
    .AD_out (AD_out),
    .AD_oe  (AD_oe),
    .A_D    (A_D),
    .CS_n   (CS_n),
    .WR_n   (WR_n),
    .RD_n   (RD_n),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Valid when both digits are decimal and the decimal value fits the field.
  function automatic bit bcd_val(input logic [7:0] v, input int max_dec);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    return (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= max_dec);
  endfunction

  function automatic logic [7:0] to_bcd(input int d);
    logic [7:0] r;
    r[7:4] = 4'(d / 10);
    r[3:0] = 4'(d % 10);
    return r;
  endfunction

  function automatic logic [7:0] rnd_field(input int max_dec);
    if ($urandom_range(0, 4) == 0) return 8'($urandom_range(0, 255));
    return to_bcd(int'($urandom_range(0, max_dec)));
  endfunction

  // Bus monitor: protocol rules every cycle, plus a log of writes, strobes and pulses.
  initial begin
    prev_cs = 1'b1;
    prev_wr = 1'b1;
    prev_ad = '0;
    wr_run = 0;
    busy_cnt = 0;
  end

  always @(negedge CLK) begin
    chk("rd_n_high", RD_n, 1'b1);
    if (CS_n === 1'b0) begin
      chk("cs_implies_wr", WR_n, 1'b0);
      chk("cs_implies_oe", AD_oe, 1'b1);
    end
    if (prev_wr === 1'b0 && WR_n === 1'b0) chk("ad_stable_wr", {A_D, AD_out}, prev_ad);
    if (prev_cs === 1'b1 && CS_n === 1'b0) wr_log.push_back({A_D, AD_out});
    if (WR_n === 1'b0) wr_run++;
    else if (wr_run > 0) begin
      pulse_log.push_back(wr_run);
      wr_run = 0;
    end
    if (DONE === 1'b1) done_log.push_back(cyc);
    if (ERR === 1'b1) err_log.push_back(cyc);
    if (BUSY === 1'b1) busy_cnt++;
    prev_cs = CS_n;
    prev_wr = WR_n;
    prev_ad = {A_D, AD_out};
  end

  task automatic clear_logs();
    wr_log.delete();
    done_log.delete();
    err_log.delete();
    pulse_log.delete();
    busy_cnt = 0;
  endtask

  task automatic run_write(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                           input bit restart);
    int t0;
    bit ok_exp;
    logic [8:0] exp_wr[6];
    ok_exp = bcd_val(s, 59) && bcd_val(m, 59) && bcd_val(h, 23);
    exp_wr = '{{1'b0, 8'h21}, {1'b1, s}, {1'b0, 8'h22}, {1'b1, m}, {1'b0, 8'h23}, {1'b1, h}};
    @(negedge CLK);
    clear_logs();
    SEG_in = s;
    MIN_in = m;
    HOR_in = h;
    START = 1'b1;
    t0 = cyc;
    @(negedge CLK);
    START = 1'b0;
    SEG_in = ~s;
    if (restart) begin
      MIN_in = 8'h01;
      HOR_in = 8'h22;
      while (cyc < t0 + 40) @(negedge CLK);
      START = 1'b1;
      SEG_in = 8'h58;
      @(negedge CLK);
      START = 1'b0;
    end
    for (int k = 0; k < 300 && done_log.size() == 0 && err_log.size() == 0; k++) @(negedge CLK);
    repeat (restart ? 80 : 6) @(negedge CLK);
    if (ok_exp) begin
      chk("done_count", done_log.size(), 1);
      if (done_log.size() > 0) chk("done_latency", done_log[0] - t0, LAT);
      chk("err_count", err_log.size(), 0);
      chk("write_count", wr_log.size(), 6);
      for (int i = 0; i < 6; i++)
        if (i < wr_log.size()) chk("bus_byte", wr_log[i], exp_wr[i]);
      chk("wr_pulse_count", pulse_log.size(), 6);
      foreach (pulse_log[i]) chk("wr_pulse_width", pulse_log[i], TP);
      chk("busy_cycles", busy_cnt, 12 * TP);
    end else begin
      chk("err_count", err_log.size(), 1);
      if (err_log.size() > 0) chk("err_latency", err_log[0] - t0, 2);
      chk("done_count", done_log.size(), 0);
      chk("write_count", wr_log.size(), 0);
      chk("busy_cycles", busy_cnt, 0);
    end
    chk("idle_busy", BUSY, 1'b0);
    chk("idle_oe", AD_oe, 1'b0);
  endtask

  task automatic reset_mid();
    int t0;
    @(negedge CLK);
    clear_logs();
    SEG_in = 8'h11;
    MIN_in = 8'h22;
    HOR_in = 8'h03;
    START = 1'b1;
    t0 = cyc;
    @(negedge CLK);
    START = 1'b0;
    while (cyc < t0 + 25) @(negedge CLK);
    chk("mid_in_data_phase", {A_D, WR_n, AD_out}, {1'b1, 1'b0, 8'h11});
    #3 RST = 1'b0;
    #1;
    chk("rst_cs_n", CS_n, 1'b1);
    chk("rst_wr_n", WR_n, 1'b1);
    chk("rst_ad_oe", AD_oe, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    repeat (3) @(negedge CLK);
    #3 RST = 1'b1;
    repeat (150) @(negedge CLK);
    chk("rst_no_done", done_log.size(), 0);
    chk("rst_writes_abandoned", wr_log.size(), 2);
    chk("rst_idle_cs", CS_n, 1'b1);
  endtask

  initial begin
    logic [7:0] rs, rm, rh;
    RST = 1'b0;
    START = 1'b0;
    SEG_in = 8'h00;
    MIN_in = 8'h00;
    HOR_in = 8'h00;
    repeat (3) @(negedge CLK);
    chk("reset_ad_out", AD_out, 8'h00);
    chk("reset_ad_oe", AD_oe, 1'b0);
    chk("reset_a_d", A_D, 1'b0);
    chk("reset_cs_n", CS_n, 1'b1);
    chk("reset_wr_n", WR_n, 1'b1);
    chk("reset_rd_n", RD_n, 1'b1);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_done", DONE, 1'b0);
    chk("reset_err", ERR, 1'b0);
    #3 RST = 1'b1;
    @(negedge CLK);

    run_write(8'h45, 8'h30, 8'h12, 1'b0);
    run_write(8'h45, 8'h30, 8'h24, 1'b0);
    run_write(8'h45, 8'h5A, 8'h12, 1'b0);
    run_write(8'h07, 8'h15, 8'h09, 1'b1);
    run_write(8'h00, 8'h00, 8'h00, 1'b0);
    run_write(8'h59, 8'h59, 8'h23, 1'b0);
    run_write(8'h60, 8'h00, 8'h00, 1'b0);
    reset_mid();
    run_write(8'h33, 8'h44, 8'h05, 1'b0);

    for (int n = 0; n < 12; n++) begin
      rs = rnd_field(59);
      rm = rnd_field(59);
      rh = rnd_field(23);
      run_write(rs, rm, rh, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
